// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with an integrated PC.
// The register at index NREGS-1 is the PC. All other registers are GPRs.
// Ports:
//   CLK, RST     - clock (rising edge) and asynchronous active-high reset
//   raddr/rdata  - NREAD packed combinational read ports (port i at [i*W +: W])
//   w0_*/w1_*    - two synchronous write ports; port 0 wins on a collision
//   pc_ld        - hazard-unit PC load enable (0 = stall)
//   pc_next      - next sequential PC
//   pc_out       - stored PC value (never bypassed)
//   wr_conflict  - registered flag: both write ports hit one address on the last edge
module regfile_mp #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       NREAD    = 3,
  parameter int unsigned       BYPASS   = 1,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREAD*ADDR_W-1:0]   raddr,
  output logic [NREAD*DATA_W-1:0]   rdata,
  input  logic                      w0_en,
  input  logic [ADDR_W-1:0]         w0_addr,
  input  logic [DATA_W-1:0]         w0_data,
  input  logic                      w1_en,
  input  logic [ADDR_W-1:0]         w1_addr,
  input  logic [DATA_W-1:0]         w1_data,
  input  logic                      pc_ld,
  input  logic [DATA_W-1:0]         pc_next,
  output logic [DATA_W-1:0]         pc_out,
  output logic                      wr_conflict
);

  localparam int unsigned       NREGS   = 1 << ADDR_W;
  localparam int unsigned       NGPR    = NREGS - 1;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0]       r_gpr [NGPR];
  logic [DATA_W-1:0]       r_pc;
  logic                    r_wr_conflict;

  logic [DATA_W-1:0]       w_regs [NREGS];
  logic [NREAD*DATA_W-1:0] w_rdata;
  logic [ADDR_W-1:0]       w_ra;
  logic [DATA_W-1:0]       w_rd;
  logic                    w_w0_pc;
  logic                    w_w1_pc;

  assign w_w0_pc = w0_en && (w0_addr == PC_ADDR);
  assign w_w1_pc = w1_en && (w1_addr == PC_ADDR);

  // GPR writes: port 0 has priority over port 1 on the same register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned r = 0; r < NGPR; r++) begin
        r_gpr[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NGPR; r++) begin
        if (w0_en && (w0_addr == ADDR_W'(r))) begin
          r_gpr[r] <= w0_data;
        end else if (w1_en && (w1_addr == ADDR_W'(r))) begin
          r_gpr[r] <= w1_data;
        end
      end
    end
  end

  // PC: a write-port write (branch) overrides both the load and a stall
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc <= RESET_PC;
    end else if (w_w0_pc) begin
      r_pc <= w0_data;
    end else if (w_w1_pc) begin
      r_pc <= w1_data;
    end else if (pc_ld) begin
      r_pc <= pc_next;
    end
  end

  // Collision flag lives for exactly one cycle after the offending edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_conflict <= w0_en && w1_en && (w0_addr == w1_addr);
    end
  end

  // Unified view of GPRs plus PC so reads index a single array
  always_comb begin
    for (int unsigned i = 0; i < NGPR; i++) begin
      w_regs[i] = r_gpr[i];
    end
    w_regs[NREGS-1] = r_pc;
  end

  // Read ports with optional same-cycle bypass in write-port priority order
  always_comb begin
    w_rdata = '0;
    w_ra    = '0;
    w_rd    = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      w_ra = raddr[i*ADDR_W +: ADDR_W];
      w_rd = w_regs[w_ra];
      if (BYPASS != 0) begin
        if (w0_en && (w0_addr == w_ra)) begin
          w_rd = w0_data;
        end else if (w1_en && (w1_addr == w_ra)) begin
          w_rd = w1_data;
        end
      end
      w_rdata[i*DATA_W +: DATA_W] = w_rd;
    end
  end

  assign rdata       = w_rdata;
  assign pc_out      = r_pc;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance (bypass), a BYPASS=0 twin sharing
// its stimulus, and a narrow 16-bit / 8-register / 2-read-port instance.
module tb_regfile_mp;

  logic        CLK;
  logic        RST;

  // stimulus shared by the bypass (a) and non-bypass (b) instances
  logic [11:0] raddr;
  logic        w0_en, w1_en, pc_ld;
  logic [3:0]  w0_addr, w1_addr;
  logic [31:0] w0_data, w1_data, pc_next;
  logic [95:0] rdata_a, rdata_b;
  logic [31:0] pc_a, pc_b;
  logic        conf_a, conf_b;

  // narrow instance
  logic [5:0]  s_raddr;
  logic        s_w0_en, s_w1_en, s_pc_ld;
  logic [2:0]  s_w0_addr, s_w1_addr;
  logic [15:0] s_w0_data, s_w1_data, s_pc_next;
  logic [31:0] s_rdata;
  logic [15:0] s_pc;
  logic        s_conf;

  int n_vec = 0;
  int n_err = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .NREAD(3), .BYPASS(1), .RESET_PC(32'h0)) u_a (
    .CLK(CLK), .RST(RST), .raddr(raddr), .rdata(rdata_a),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .pc_ld(pc_ld), .pc_next(pc_next), .pc_out(pc_a), .wr_conflict(conf_a));

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .NREAD(3), .BYPASS(0), .RESET_PC(32'h0)) u_b (
    .CLK(CLK), .RST(RST), .raddr(raddr), .rdata(rdata_b),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .pc_ld(pc_ld), .pc_next(pc_next), .pc_out(pc_b), .wr_conflict(conf_b));

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(2), .BYPASS(1), .RESET_PC(16'h8)) u_s (
    .CLK(CLK), .RST(RST), .raddr(s_raddr), .rdata(s_rdata),
    .w0_en(s_w0_en), .w0_addr(s_w0_addr), .w0_data(s_w0_data),
    .w1_en(s_w1_en), .w1_addr(s_w1_addr), .w1_data(s_w1_data),
    .pc_ld(s_pc_ld), .pc_next(s_pc_next), .pc_out(s_pc), .wr_conflict(s_conf));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        w0_en;
    logic [3:0]  w0_addr;
    logic [31:0] w0_data;
    logic        w1_en;
    logic [3:0]  w1_addr;
    logic [31:0] w1_data;
    logic        pc_ld;
    logic [31:0] pc_next;
    logic [3:0]  ra;
    logic [31:0] exp_pre_byp;
    logic [31:0] exp_pre_nb;
    logic [31:0] exp_post_rd;
    logic [31:0] exp_pc;
    logic        exp_conf;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    w0_en = 1'b0; w0_addr = '0; w0_data = '0;
    w1_en = 1'b0; w1_addr = '0; w1_data = '0;
    pc_ld = 1'b0; pc_next = '0; raddr = '0;
    s_w0_en = 1'b0; s_w0_addr = '0; s_w0_data = '0;
    s_w1_en = 1'b0; s_w1_addr = '0; s_w1_data = '0;
    s_pc_ld = 1'b0; s_pc_next = '0; s_raddr = '0;
  endtask

  logic [31:0] pc_prev;

  initial begin
    tbl[0]  = '{1'b1, 4'd5,  32'hAAAA, 1'b1, 4'd5,  32'h5555, 1'b0, 32'h0,   4'd5,  32'hAAAA, 32'd16,   32'hAAAA, 32'h0,   1'b1};
    tbl[1]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    1'b0, 32'h0,   4'd5,  32'hAAAA, 32'hAAAA, 32'hAAAA, 32'h0,   1'b0};
    tbl[2]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd15, 32'h100,  1'b1, 32'h10,  4'd15, 32'h100,  32'h0,    32'h100,  32'h100, 1'b0};
    tbl[3]  = '{1'b1, 4'd15, 32'h200,  1'b0, 4'd0,  32'h0,    1'b0, 32'h0,   4'd15, 32'h200,  32'h100,  32'h200,  32'h200, 1'b0};
    tbl[4]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    1'b1, 32'h204, 4'd15, 32'h200,  32'h200,  32'h204,  32'h204, 1'b0};
    tbl[5]  = '{1'b1, 4'd3,  32'd7,    1'b0, 4'd0,  32'h0,    1'b0, 32'h0,   4'd3,  32'd7,    32'd10,   32'd7,    32'h204, 1'b0};
    tbl[6]  = '{1'b1, 4'd3,  32'd90,   1'b0, 4'd0,  32'h0,    1'b0, 32'h0,   4'd3,  32'd90,   32'd7,    32'd90,   32'h204, 1'b0};
    tbl[7]  = '{1'b1, 4'd7,  32'h11,   1'b1, 4'd7,  32'h22,   1'b1, 32'h300, 4'd7,  32'h11,   32'd22,   32'h11,   32'h300, 1'b1};
    tbl[8]  = '{1'b1, 4'd2,  32'h33,   1'b1, 4'd15, 32'h400,  1'b1, 32'h500, 4'd15, 32'h400,  32'h300,  32'h400,  32'h400, 1'b0};
    tbl[9]  = '{1'b0, 4'd9,  32'hDEAD, 1'b1, 4'd9,  32'h99,   1'b0, 32'h0,   4'd9,  32'h99,   32'd28,   32'h99,   32'h400, 1'b0};
    tbl[10] = '{1'b1, 4'd15, 32'h600,  1'b1, 4'd15, 32'h700,  1'b1, 32'h800, 4'd15, 32'h600,  32'h400,  32'h600,  32'h600, 1'b1};

    idle_inputs();
    RST = 1'b1;

    // reset state
    #12;
    chk("rst_pc_a", pc_a, 32'h0);
    chk("rst_pc_b", pc_b, 32'h0);
    chk("rst_pc_s", 32'(s_pc), 32'h8);
    chk("rst_rd_a", rdata_a[31:0], 32'h0);
    chk("rst_rd_s", s_rdata, 32'h0);
    chk("rst_conf", 32'({conf_a, conf_b, s_conf}), 32'h0);

    // stall: pc_ld low keeps PC at its reset value
    @(negedge CLK);
    RST = 1'b0;
    pc_next = 32'h40;
    raddr = {4'd15, 4'd1, 4'd0};
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk("stall_pc", pc_a, 32'h0);
      chk("stall_rd", 32'(rdata_b[95:64] | rdata_b[63:32] | rdata_b[31:0]), 32'h0);
      chk("stall_conf", 32'(conf_a), 32'h0);
    end

    // write and read back every GPR
    for (int r = 0; r < 15; r++) begin
      @(negedge CLK);
      w0_en = 1'b1; w0_addr = 4'(r); w0_data = 32'(r*3+1);
      raddr = {4'(r), 4'(r), 4'(r)};
      #1;
      for (int p = 0; p < 3; p++) begin
        chk("wr_pre_byp", rdata_a[p*32 +: 32], 32'(r*3+1));
        chk("wr_pre_nb", rdata_b[p*32 +: 32], 32'h0);
      end
      @(posedge CLK); #1;
      for (int p = 0; p < 3; p++) begin
        chk("wr_post", rdata_b[p*32 +: 32], 32'(r*3+1));
      end
    end
    @(negedge CLK);
    w0_en = 1'b0;
    for (int r = 0; r < 15; r++) begin
      raddr = {4'(r), 4'(r), 4'(r)};
      #1;
      chk("rdback_b", rdata_b[31:0], 32'(r*3+1));
      chk("rdback_a", rdata_a[95:64], 32'(r*3+1));
    end
    chk("rdback_pc", pc_a, 32'h0);

    // table: collisions, PC priority, bypass behaviour
    pc_prev = 32'h0;
    for (int v = 0; v < 11; v++) begin
      @(negedge CLK);
      w0_en = tbl[v].w0_en; w0_addr = tbl[v].w0_addr; w0_data = tbl[v].w0_data;
      w1_en = tbl[v].w1_en; w1_addr = tbl[v].w1_addr; w1_data = tbl[v].w1_data;
      pc_ld = tbl[v].pc_ld; pc_next = tbl[v].pc_next;
      raddr = {tbl[v].ra, tbl[v].ra, tbl[v].ra};
      #1;
      chk($sformatf("v%0d_pre_byp", v), rdata_a[31:0], tbl[v].exp_pre_byp);
      chk($sformatf("v%0d_pre_nb", v), rdata_b[31:0], tbl[v].exp_pre_nb);
      chk($sformatf("v%0d_pre_pc", v), pc_a, pc_prev);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_post_rd", v), rdata_b[31:0], tbl[v].exp_post_rd);
      chk($sformatf("v%0d_pc_a", v), pc_a, tbl[v].exp_pc);
      chk($sformatf("v%0d_pc_b", v), pc_b, tbl[v].exp_pc);
      chk($sformatf("v%0d_conf", v), 32'(conf_a), 32'(tbl[v].exp_conf));
      pc_prev = tbl[v].exp_pc;
    end

    // asynchronous reset between edges
    @(negedge CLK);
    w0_en = 1'b1; w0_addr = 4'd10; w0_data = 32'd16;
    w1_en = 1'b1; w1_addr = 4'd15; w1_data = 32'h24;
    pc_ld = 1'b0; raddr = {4'd10, 4'd10, 4'd10};
    @(posedge CLK); #1;
    chk("ar_pre_r10", rdata_b[31:0], 32'd16);
    chk("ar_pre_pc", pc_b, 32'h24);
    @(negedge CLK);
    w0_en = 1'b0; w1_en = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("ar_r10_a", rdata_a[31:0], 32'h0);
    chk("ar_r10_b", rdata_b[31:0], 32'h0);
    chk("ar_pc_a", pc_a, 32'h0);
    chk("ar_pc_s", 32'(s_pc), 32'h8);
    #1 RST = 1'b0;
    pc_ld = 1'b1; pc_next = 32'h4;
    @(posedge CLK); #1;
    chk("ar_pc_ld", pc_a, 32'h4);
    chk("ar_pc_ld_b", pc_b, 32'h4);
    @(negedge CLK);
    idle_inputs();

    // narrow instance: write/read every GPR
    for (int r = 0; r < 7; r++) begin
      @(negedge CLK);
      s_w0_en = 1'b1; s_w0_addr = 3'(r); s_w0_data = 16'(r*3+1);
      s_raddr = {3'(r), 3'(r)};
      #1;
      chk("s_wr_pre", s_rdata, {16'(r*3+1), 16'(r*3+1)});
      @(posedge CLK); #1;
      chk("s_wr_post", s_rdata, {16'(r*3+1), 16'(r*3+1)});
    end
    @(negedge CLK);
    s_w0_en = 1'b0;
    for (int r = 0; r < 7; r++) begin
      s_raddr = {3'(r), 3'(r)};
      #1;
      chk("s_rdback", s_rdata, {16'(r*3+1), 16'(r*3+1)});
    end
    chk("s_pc_hold", 32'(s_pc), 32'h8);

    // narrow instance: PC priority and collision
    @(negedge CLK);
    s_pc_ld = 1'b1; s_pc_next = 16'h10;
    s_w1_en = 1'b1; s_w1_addr = 3'd7; s_w1_data = 16'h100;
    s_raddr = {3'd0, 3'd7};
    #1;
    chk("s_pc_byp", s_rdata[15:0], 16'h100);
    chk("s_pc_out_pre", 32'(s_pc), 32'h8);
    @(posedge CLK); #1;
    chk("s_pc_w1", 32'(s_pc), 32'h100);
    @(negedge CLK);
    s_pc_ld = 1'b0; s_w1_en = 1'b0;
    s_w0_en = 1'b1; s_w0_addr = 3'd7; s_w0_data = 16'h200;
    @(posedge CLK); #1;
    chk("s_pc_w0", 32'(s_pc), 32'h200);
    @(negedge CLK);
    s_pc_ld = 1'b1; s_pc_next = 16'h12;
    s_w0_en = 1'b1; s_w0_addr = 3'd4; s_w0_data = 16'hAAAA;
    s_w1_en = 1'b1; s_w1_addr = 3'd4; s_w1_data = 16'h5555;
    s_raddr = {3'd4, 3'd4};
    @(posedge CLK); #1;
    chk("s_pc_ld", 32'(s_pc), 32'h12);
    chk("s_coll_r4", s_rdata, 32'hAAAAAAAA);
    chk("s_conf_set", 32'(s_conf), 32'h1);
    @(negedge CLK);
    s_w0_en = 1'b0; s_w1_en = 1'b0; s_pc_ld = 1'b0;
    @(posedge CLK); #1;
    chk("s_conf_clr", 32'(s_conf), 32'h0);
    chk("s_r4_hold", s_rdata[15:0], 16'hAAAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU datapath; successor to the fixed 16x32, 3-read, 1-write file.
- Provides NREAD combinational read ports, two synchronous write ports and optional write-to-read bypass.
- The top register (index NREGS-1) is the PC. It has its own hazard-gated load path with a defined priority against the write ports.
- Sits between decode (read addresses) and writeback (W0 = ALU/load result, W1 = base-register writeback).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, address width; NREGS = 2**ADDR_W registers.
- NREAD, 3, number of read ports.
- BYPASS, 1, 1 = a read returns same-cycle write data on an address match; 0 = a read returns stored contents only.
- RESET_PC, 0, PC value after reset.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high; clock CLK.
- raddr  in  NREAD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  packed read data, same packing as raddr.
- w0_en  in  1  write port 0 enable.
- w0_addr  in  ADDR_W  write port 0 address.
- w0_data  in  DATA_W  write port 0 data.
- w1_en  in  1  write port 1 enable.
- w1_addr  in  ADDR_W  write port 1 address.
- w1_data  in  DATA_W  write port 1 data.
- pc_ld  in  1  hazard-unit PC load enable; 0 = stall.
- pc_next  in  DATA_W  next sequential PC, computed externally.
- pc_out  out  DATA_W  current PC register value.
- wr_conflict  out  1  registered flag: previous edge had both write ports enabled on the same address.

Behaviour:
- Reset (RST=1, asynchronous, independent of CLK):
  - GPRs 0..NREGS-2 clear to 0.
  - PC loads RESET_PC.
  - wr_conflict clears to 0.
  - Writes and pc_ld are ignored while RST is high.
  - Deassertion mid-operation: the first rising edge with RST=0 performs a normal update.
- GPR write, per register r < NREGS-1, on a rising edge:
  - If w0_en and w0_addr==r: r <= w0_data.
  - Else if w1_en and w1_addr==r: r <= w1_data.
  - Else r holds.
  - Port 0 always wins a collision.
- PC update on a rising edge, priority high to low:
  1. w0 targets the PC: PC <= w0_data.
  2. w1 targets the PC: PC <= w1_data.
  3. pc_ld=1: PC <= pc_next.
  4. Otherwise PC holds.
  - A write-port write to the PC takes effect even when pc_ld=0. A branch overrides a stall.
- wr_conflict: set on an edge <= (w0_en & w1_en & w0_addr==w1_addr); it is 1 for exactly the following cycle.
- Read, combinational, zero latency:
  - rdata[i] = reg[raddr[i]]; address NREGS-1 returns the PC value.
  - BYPASS=1: if w0 is enabled and matches raddr[i], return w0_data; else if w1 is enabled and matches, return w1_data.
  - Bypass uses the same port priority as the write logic and also applies to PC reads.
  - BYPASS=0: the new value is visible only after the edge.
- pc_out = stored PC and is never bypassed. rdata of address NREGS-1 may differ from pc_out only when BYPASS=1 and a write is pending.
- All read ports are independent; any number may select the same address.
- No X on outputs after reset. Undriven or disabled write data has no effect.
- Width rules: data is passed unmodified, with no sign or zero extension. Addresses are exactly ADDR_W bits, so no out-of-range case exists.

Test Plan:
- Reset and stall: assert RST, release; hold pc_ld=0, pc_next=0x40 for 3 edges -> pc_out=RESET_PC (0) throughout, all rdata=0, wr_conflict=0.
- Write/read every GPR: for r=0..14 write w0_data=r*3+1, then read r on all 3 ports -> next cycle rdata=r*3+1 on every port. Registers not written remain 0.
- Collision: w0 (addr 5, 0xAAAA) and w1 (addr 5, 0x5555) on the same edge -> R5=0xAAAA; wr_conflict=1 for one cycle only. BYPASS=1 read of R5 before the edge -> 0xAAAA.
- PC priority: pc_ld=1, pc_next=0x10; same edge w1 writes PC=0x100 -> pc_out=0x100. Next edge, pc_ld=0 and w0 writes PC=0x200 -> pc_out=0x200.
- Bypass: BYPASS=1, R3=7; drive w0 (addr 3, 90) with raddr0=3 -> rdata0=90 before the edge and pc_out unaffected. With BYPASS=0 the same stimulus -> rdata0=7 until the edge, then 90.
- Async reset mid-run: R10=16, PC=0x24; pulse RST between clock edges -> R10=0, PC=0 immediately. The next edge with pc_ld=1, pc_next=4 -> pc_out=4.
- Parameter sweep: DATA_W=16, ADDR_W=3, NREAD=2, RESET_PC=0x8 -> repeat the write/read and PC-priority scenarios; PC is register 7 and resets to 0x8.
